wbu_commit_stage: RTL and testbench
===================================

Name: wbu_commit_stage

Overview:
- Writeback/commit stage directly upstream of the integer register file and CSR register block.
- Holds one completed instruction from EXU/LSU in a single-entry pipeline register and selects the writeback data.
- Issues one-cycle commit strobes to the register file and the CSR block, including the ecall/mret trap signal.
- Hands the next PC to the IFU over a valid/ready handshake and counts retired instructions.

Parameters:
- XLEN, 32, data/PC width.
- ADDR_WIDTH, 5, register-file address width.
- RESET_PC, 32'h8000_0000, next_pc value driven while the stage is empty after reset.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EXU/LSU result valid.
- in_ready  out  1  stage can accept.
- in_pc  in  XLEN  PC of the instruction.
- in_alu  in  XLEN  ALU result.
- in_lsu  in  XLEN  load data.
- in_csr_rdata  in  XLEN  old CSR value, for csrr*.
- in_wb_sel  in  2  writeback source: 0 alu, 1 lsu, 2 csr, 3 pc+4.
- in_rd  in  ADDR_WIDTH  destination register.
- in_rd_wen  in  1  register write requested.
- in_csr_wen  in  1  CSR write requested.
- in_csr_wdata  in  XLEN  new CSR value.
- in_jump  in  1  taken branch/jump.
- in_target  in  XLEN  jump target.
- in_ecall  in  1  ecall.
- in_mret  in  1  mret.
- csr_data_pc  in  XLEN  trap/return vector from the CSR block.
- rf_wdata  out  XLEN  register-file write data.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wen  out  1  register write request.
- rf_valid  out  1  commit strobe (the register file's in_valid).
- csr_wdata  out  XLEN  CSR write data.
- csr_wen  out  1  CSR write request.
- ecall_single  out  1  trap indication to the CSR block.
- ecall_now_pc  out  XLEN  PC of the trapping instruction.
- out_valid  out  1  next_pc valid to IFU.
- out_ready  in  1  IFU accepts.
- next_pc  out  XLEN  fetch address.
- instret  out  64  retired-instruction count.

Behaviour:
- State: S_EMPTY / S_FULL, plus one entry register holding all in_* fields except csr_data_pc.
- Accept:
  - in_ready = (state==S_EMPTY) | commit, where commit = (state==S_FULL) & out_ready.
  - Capture on in_valid & in_ready.
  - Accept and commit in the same cycle is legal. The new entry replaces the committing one and state stays S_FULL, giving full throughput of one instruction per cycle.
- Transitions:
  - S_EMPTY -> S_FULL on accept.
  - S_FULL -> S_EMPTY on commit without accept.
  - Otherwise hold.
  - The entry is stable while out_valid & !out_ready.
- Output strobes:
  - out_valid = (state==S_FULL).
  - rf_valid = commit. rf_wen = commit & e.rd_wen. csr_wen = commit & e.csr_wen.
  - rf_wen is a pure function of the stored fields; x0 suppression is left to the register file.
- rf_wdata is a combinational mux on e.wb_sel. Source 3 is e.pc+4, truncated to XLEN with wrap-around: 32'hFFFF_FFFC+4 = 0.
- ecall_single = (state==S_FULL) & e.ecall, held for the whole S_FULL period so the CSR block presents mtvec on csr_data_pc. ecall_now_pc = e.pc.
- next_pc priority:
  1. ecall or mret -> csr_data_pc.
  2. jump -> e.target.
  3. else e.pc+4.
  - In S_EMPTY, next_pc holds the last committed value; it is RESET_PC after reset.
  - Simultaneous ecall and mret: ecall wins. Both vectors come from csr_data_pc, and ecall_single already selects mtvec.
- instret:
  - +1 on every commit, 64-bit, wraps from all-ones to 0.
  - Not incremented for S_EMPTY cycles or stalled S_FULL cycles.
- Reset (reset==0, asynchronous):
  - state=S_EMPTY, entry cleared, instret=0, next_pc=RESET_PC.
  - All strobes 0: rf_valid, rf_wen, csr_wen, ecall_single, out_valid.
  - All data outputs 0, except next_pc.
  - An in-flight entry is dropped without writing.
  - Deassertion takes effect on the first clock edge after release. in_ready=1 in the first cycle after release.

Decomposition:
- Shared package:
  - wb_sel encodings (WB_ALU, WB_LSU, WB_CSR, WB_PC4).
  - State encodings (S_EMPTY, S_FULL).
  - Packed entry struct typedef.
  - RESET_PC constant.
- One natural sub-module, wbu_next_pc_sel: a combinational next-PC priority mux. Everything else stays inline.

Test Plan:
- Back-to-back ALU ops, out_ready=1:
  - Input: rd=5 alu=32'h1234, then rd=6 alu=32'h55.
  - Required: rf_wen pulses on consecutive cycles with waddr 5 then 6; in_ready stays 1; instret goes 0->1->2.
- IFU stall:
  - Input: accept a load (wb_sel=1, lsu=32'hDEAD_BEEF), out_ready=0 for 3 cycles.
  - Required: in_ready=0, no rf_wen, entry stable throughout.
  - On the out_ready=1 cycle: rf_wdata=32'hDEAD_BEEF, rf_wen=1, instret +1.
- ecall:
  - Input: in_ecall at pc=32'h8000_0010, csr_data_pc=32'h8000_0100.
  - Required: ecall_single=1 while S_FULL, ecall_now_pc=32'h8000_0010, next_pc=32'h8000_0100; no rf_wen.
- jal:
  - Input: wb_sel=3, pc=32'hFFFF_FFFC, jump=1, target=32'h8000_0000.
  - Required: rf_wdata=0 (wrap-around), next_pc=32'h8000_0000.
- Reset mid-operation:
  - Input: entry valid with out_ready=0, reset pulled low asynchronously.
  - Required: out_valid=0, rf_wen=0 and instret=0 immediately, next_pc=RESET_PC, no commit after release.
- instret wrap:
  - Input: force the count to 64'hFFFF_FFFF_FFFF_FFFF, commit one instruction.
  - Required: instret=0.

Source files
------------

// File: rtl/wbu_commit_stage_pkg.sv
// Shared types and constants for the writeback/commit stage.
package wbu_commit_stage_pkg;

  localparam int WBU_XLEN       = 32;
  localparam int WBU_ADDR_WIDTH = 5;
  localparam logic [WBU_XLEN-1:0] WBU_RESET_PC = 32'h8000_0000;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LSU = 2'd1,
    WB_CSR = 2'd2,
    WB_PC4 = 2'd3
  } wb_sel_e;

  // Single-entry occupancy
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  // One completed instruction as held by the stage
  typedef struct packed {
    logic [WBU_XLEN-1:0]       pc;
    logic [WBU_XLEN-1:0]       alu;
    logic [WBU_XLEN-1:0]       lsu;
    logic [WBU_XLEN-1:0]       csr_rdata;
    wb_sel_e                   wb_sel;
    logic [WBU_ADDR_WIDTH-1:0] rd;
    logic                      rd_wen;
    logic                      csr_wen;
    logic [WBU_XLEN-1:0]       csr_wdata;
    logic                      jump;
    logic [WBU_XLEN-1:0]       target;
    logic                      ecall;
    logic                      mret;
  } entry_t;

endpackage

// File: rtl/wbu_commit_stage_if.sv
// EXU/LSU -> writeback result bus with its valid/ready handshake.
interface wbu_commit_stage_if;
  import wbu_commit_stage_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [WBU_XLEN-1:0]       in_pc;
  logic [WBU_XLEN-1:0]       in_alu;
  logic [WBU_XLEN-1:0]       in_lsu;
  logic [WBU_XLEN-1:0]       in_csr_rdata;
  logic [1:0]                in_wb_sel;
  logic [WBU_ADDR_WIDTH-1:0] in_rd;
  logic                      in_rd_wen;
  logic                      in_csr_wen;
  logic [WBU_XLEN-1:0]       in_csr_wdata;
  logic                      in_jump;
  logic [WBU_XLEN-1:0]       in_target;
  logic                      in_ecall;
  logic                      in_mret;

  // Producer side (EXU/LSU)
  modport master (
    output in_valid, in_pc, in_alu, in_lsu, in_csr_rdata, in_wb_sel, in_rd,
           in_rd_wen, in_csr_wen, in_csr_wdata, in_jump, in_target,
           in_ecall, in_mret,
    input  in_ready
  );

  // Consumer side (commit stage)
  modport slave (
    input  in_valid, in_pc, in_alu, in_lsu, in_csr_rdata, in_wb_sel, in_rd,
           in_rd_wen, in_csr_wen, in_csr_wdata, in_jump, in_target,
           in_ecall, in_mret,
    output in_ready
  );

endinterface

// File: rtl/wbu_next_pc_sel.sv
// Next-PC priority mux: trap/return vector, then jump target, then pc+4.
module wbu_next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] target_i,
  input  logic [XLEN-1:0] csr_data_pc_i,
  output logic [XLEN-1:0] next_pc_o
);

  // ecall and mret share csr_data_pc; the CSR block picks mtvec vs mepc
  always_comb begin
    next_pc_o = pc_i + XLEN'(4);
    if (ecall_i || mret_i) begin
      next_pc_o = csr_data_pc_i;
    end else if (jump_i) begin
      next_pc_o = target_i;
    end
  end

endmodule

// File: rtl/wbu_commit_stage.sv
// Writeback/commit stage: single-entry buffer, writeback mux, commit
// strobes to the register file and CSR block, next-PC handoff, instret.
module wbu_commit_stage
  import wbu_commit_stage_pkg::*;
#(
  parameter int XLEN       = WBU_XLEN,
  parameter int ADDR_WIDTH = WBU_ADDR_WIDTH,
  parameter logic [XLEN-1:0] RESET_PC = WBU_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  wbu_commit_stage_if.slave     in_bus,
  input  logic [XLEN-1:0]       csr_data_pc,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic                  rf_wen,
  output logic                  rf_valid,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  csr_wen,
  output logic                  ecall_single,
  output logic [XLEN-1:0]       ecall_now_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       next_pc,
  output logic [63:0]           instret
);

  state_e          state_q, state_d;
  entry_t          entry_q, entry_d;
  logic [63:0]     instret_q, instret_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [XLEN-1:0] sel_pc;
  logic            full;
  logic            commit;
  logic            accept;

  assign full            = (state_q == S_FULL);
  assign commit          = full & out_ready;
  assign in_bus.in_ready = (state_q == S_EMPTY) | commit;
  assign accept          = in_bus.in_valid & in_bus.in_ready;

  wbu_next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .ecall_i       (entry_q.ecall),
    .mret_i        (entry_q.mret),
    .jump_i        (entry_q.jump),
    .pc_i          (entry_q.pc),
    .target_i      (entry_q.target),
    .csr_data_pc_i (csr_data_pc),
    .next_pc_o     (sel_pc)
  );

  // Next state: capture on accept (may overlap a commit), drain on commit
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    instret_d = instret_q;
    last_pc_d = last_pc_q;
    if (accept) begin
      state_d           = S_FULL;
      entry_d.pc        = in_bus.in_pc;
      entry_d.alu       = in_bus.in_alu;
      entry_d.lsu       = in_bus.in_lsu;
      entry_d.csr_rdata = in_bus.in_csr_rdata;
      entry_d.wb_sel    = wb_sel_e'(in_bus.in_wb_sel);
      entry_d.rd        = in_bus.in_rd;
      entry_d.rd_wen    = in_bus.in_rd_wen;
      entry_d.csr_wen   = in_bus.in_csr_wen;
      entry_d.csr_wdata = in_bus.in_csr_wdata;
      entry_d.jump      = in_bus.in_jump;
      entry_d.target    = in_bus.in_target;
      entry_d.ecall     = in_bus.in_ecall;
      entry_d.mret      = in_bus.in_mret;
    end else if (commit) begin
      state_d = S_EMPTY;
    end
    if (commit) begin
      instret_d = instret_q + 64'd1;
      last_pc_d = sel_pc;
    end
  end

  // State registers; reset drops any in-flight entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_EMPTY;
      entry_q   <= '0;
      instret_q <= '0;
      last_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      instret_q <= instret_d;
      last_pc_q <= last_pc_d;
    end
  end

  // Writeback data select; pc+4 wraps at XLEN
  always_comb begin
    rf_wdata = entry_q.alu;
    case (entry_q.wb_sel)
      WB_ALU: rf_wdata = entry_q.alu;
      WB_LSU: rf_wdata = entry_q.lsu;
      WB_CSR: rf_wdata = entry_q.csr_rdata;
      WB_PC4: rf_wdata = entry_q.pc + XLEN'(4);
      default: rf_wdata = entry_q.alu;
    endcase
  end

  assign rf_waddr     = entry_q.rd;
  assign rf_valid     = commit;
  assign rf_wen       = commit & entry_q.rd_wen;
  assign csr_wen      = commit & entry_q.csr_wen;
  assign csr_wdata    = entry_q.csr_wdata;
  assign ecall_single = full & entry_q.ecall;
  assign ecall_now_pc = entry_q.pc;
  assign out_valid    = full;
  assign next_pc      = full ? sel_pc : last_pc_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_wbu_commit_stage.sv
// Directed bench for wbu_commit_stage: inputs driven on the falling edge,
// outputs checked 1 ns later, the rising edge does the capture/commit.
module tb_wbu_commit_stage;

  logic        clock;
  logic        reset;
  logic [31:0] csr_data_pc;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_wen;
  logic        rf_valid;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic        ecall_single;
  logic [31:0] ecall_now_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] next_pc;
  logic [63:0] instret;

  int n_cmp;
  int n_fail;

  wbu_commit_stage_if bus();

  wbu_commit_stage dut (
    .clock        (clock),
    .reset        (reset),
    .in_bus       (bus),
    .csr_data_pc  (csr_data_pc),
    .rf_wdata     (rf_wdata),
    .rf_waddr     (rf_waddr),
    .rf_wen       (rf_wen),
    .rf_valid     (rf_valid),
    .csr_wdata    (csr_wdata),
    .csr_wen      (csr_wen),
    .ecall_single (ecall_single),
    .ecall_now_pc (ecall_now_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .next_pc      (next_pc),
    .instret      (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_pc        = '0;
    bus.in_alu       = '0;
    bus.in_lsu       = '0;
    bus.in_csr_rdata = '0;
    bus.in_wb_sel    = 2'd0;
    bus.in_rd        = '0;
    bus.in_rd_wen    = 1'b0;
    bus.in_csr_wen   = 1'b0;
    bus.in_csr_wdata = '0;
    bus.in_jump      = 1'b0;
    bus.in_target    = '0;
    bus.in_ecall     = 1'b0;
    bus.in_mret      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b0;
    csr_data_pc = '0;
    idle_inputs();
    @(negedge clock); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    n_cmp++; if (next_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_next_pc got %h want 80000000", next_pc); end
    n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", instret); end
    n_cmp++; if ({rf_valid, rf_wen, csr_wen, ecall_single} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes got %b want 0000", {rf_valid, rf_wen, csr_wen, ecall_single}); end
    n_cmp++; if ({rf_wdata, rf_waddr, csr_wdata, ecall_now_pc} !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", {rf_wdata, rf_waddr, csr_wdata, ecall_now_pc}); end
    reset = 1'b1;
    @(negedge clock); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
    $display("reset: done");
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0000; bus.in_alu = 32'h1234;
    bus.in_rd = 5'd5; bus.in_rd_wen = 1'b1; bus.in_wb_sel = 2'd0;
    #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_wen got %0b want 0", rf_wen); end
    @(negedge clock);
    bus.in_pc = 32'h8000_0004; bus.in_alu = 32'h55; bus.in_rd = 5'd6;
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL b2b_first got wen=%0b addr=%0d data=%h want 1/5/1234", rf_wen, rf_waddr, rf_wdata); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %0b want 1", bus.in_ready); end
    n_cmp++; if (instret !== 64'd0 || next_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL b2b_first_pc got instret=%0d npc=%h want 0/80000004", instret, next_pc); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h55) begin n_fail++; $display("FAIL b2b_second got wen=%0b addr=%0d data=%h want 1/6/55", rf_wen, rf_waddr, rf_wdata); end
    n_cmp++; if (instret !== 64'd1 || next_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL b2b_second_pc got instret=%0d npc=%h want 1/80000008", instret, next_pc); end
    @(negedge clock); #1;
    n_cmp++; if (instret !== 64'd2 || out_valid !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got instret=%0d ov=%0b wen=%0b want 2/0/0", instret, out_valid, rf_wen); end
    n_cmp++; if (next_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL b2b_hold_pc got %h want 80000008", next_pc); end
    $display("back_to_back: done");
  endtask

  task automatic test_stall();
    @(negedge clock);
    out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0008; bus.in_lsu = 32'hDEAD_BEEF;
    bus.in_wb_sel = 2'd1; bus.in_rd = 5'd7; bus.in_rd_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      idle_inputs();
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0 || rf_wen !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got rdy=%0b wen=%0b ov=%0b want 0/0/1", i, bus.in_ready, rf_wen, out_valid); end
      n_cmp++; if (rf_wdata !== 32'hDEAD_BEEF || rf_waddr !== 5'd7 || instret !== 64'd2) begin n_fail++; $display("FAIL stall_entry%0d got data=%h addr=%0d instret=%0d want deadbeef/7/2", i, rf_wdata, rf_waddr, instret); end
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_valid !== 1'b1 || rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_commit got wen=%0b v=%0b data=%h want 1/1/deadbeef", rf_wen, rf_valid, rf_wdata); end
    @(negedge clock); #1;
    n_cmp++; if (instret !== 64'd3) begin n_fail++; $display("FAIL stall_instret got %0d want 3", instret); end
    $display("stall: done");
  endtask

  task automatic test_ecall();
    @(negedge clock);
    out_ready = 1'b0;
    csr_data_pc = 32'h8000_0100;
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0010; bus.in_ecall = 1'b1;
    bus.in_jump = 1'b1; bus.in_target = 32'h1111_1110;
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (ecall_single !== 1'b1 || ecall_now_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL ecall_held got es=%0b pc=%h want 1/80000010", ecall_single, ecall_now_pc); end
    n_cmp++; if (next_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL ecall_next_pc got %h want 80000100", next_pc); end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (ecall_single !== 1'b1 || rf_wen !== 1'b0 || rf_valid !== 1'b1) begin n_fail++; $display("FAIL ecall_commit got es=%0b wen=%0b v=%0b want 1/0/1", ecall_single, rf_wen, rf_valid); end
    @(negedge clock);
    csr_data_pc = 32'h0;
    #1;
    n_cmp++; if (ecall_single !== 1'b0 || next_pc !== 32'h8000_0100 || instret !== 64'd4) begin n_fail++; $display("FAIL ecall_after got es=%0b npc=%h instret=%0d want 0/80000100/4", ecall_single, next_pc, instret); end
    $display("ecall: done");
  endtask

  task automatic test_csr_mret();
    @(negedge clock);
    out_ready = 1'b0;
    csr_data_pc = 32'h8000_0200;
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0020; bus.in_wb_sel = 2'd2;
    bus.in_csr_rdata = 32'hAAAA_0001; bus.in_csr_wdata = 32'hBBBB_0002;
    bus.in_csr_wen = 1'b1; bus.in_rd = 5'd9; bus.in_rd_wen = 1'b1; bus.in_mret = 1'b1;
    @(negedge clock);
    idle_inputs();
    out_ready = 1'b1;
    #1;
    n_cmp++; if (rf_wdata !== 32'hAAAA_0001 || csr_wdata !== 32'hBBBB_0002 || csr_wen !== 1'b1) begin n_fail++; $display("FAIL csr_commit got rd=%h cw=%h cwen=%0b want aaaa0001/bbbb0002/1", rf_wdata, csr_wdata, csr_wen); end
    n_cmp++; if (next_pc !== 32'h8000_0200 || ecall_single !== 1'b0) begin n_fail++; $display("FAIL mret_next_pc got npc=%h es=%0b want 80000200/0", next_pc, ecall_single); end
    @(negedge clock); #1;
    n_cmp++; if (instret !== 64'd5 || csr_wen !== 1'b0) begin n_fail++; $display("FAIL csr_after got instret=%0d cwen=%0b want 5/0", instret, csr_wen); end
    $display("csr_mret: done");
  endtask

  task automatic test_jal();
    @(negedge clock);
    out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'hFFFF_FFFC; bus.in_wb_sel = 2'd3;
    bus.in_jump = 1'b1; bus.in_target = 32'h8000_0000; bus.in_rd = 5'd1; bus.in_rd_wen = 1'b1;
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (rf_wdata !== 32'h0 || next_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL jal_data got rd=%h npc=%h want 0/80000000", rf_wdata, next_pc); end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1) begin n_fail++; $display("FAIL jal_commit got wen=%0b addr=%0d want 1/1", rf_wen, rf_waddr); end
    @(negedge clock); #1;
    n_cmp++; if (instret !== 64'd6) begin n_fail++; $display("FAIL jal_instret got %0d want 6", instret); end
    $display("jal: done");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0030; bus.in_alu = 32'h77;
    bus.in_rd = 5'd3; bus.in_rd_wen = 1'b1; bus.in_ecall = 1'b1;
    @(negedge clock);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || rf_wen !== 1'b0 || ecall_single !== 1'b0) begin n_fail++; $display("FAIL rmid_strobes got ov=%0b wen=%0b es=%0b want 0/0/0", out_valid, rf_wen, ecall_single); end
    n_cmp++; if (instret !== 64'd0 || next_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL rmid_state got instret=%0d npc=%h want 0/80000000", instret, next_pc); end
    n_cmp++; if (rf_wdata !== 32'h0 || ecall_now_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_data got rd=%h epc=%h want 0/0", rf_wdata, ecall_now_pc); end
    out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++; if (rf_valid !== 1'b0 || out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release got v=%0b ov=%0b rdy=%0b want 0/0/1", rf_valid, out_valid, bus.in_ready); end
    @(negedge clock); #1;
    n_cmp++; if (instret !== 64'd0 || rf_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_nocommit got instret=%0d v=%0b want 0/0", instret, rf_valid); end
    $display("reset_mid: done");
  endtask

  task automatic test_instret_wrap();
    @(negedge clock);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0040; bus.in_alu = 32'h9; bus.in_rd = 5'd2; bus.in_rd_wen = 1'b1;
    #1;
    release dut.instret_q;
    #1;
    n_cmp++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL wrap_preset got %h want ffffffffffffffff", instret); end
    @(negedge clock);
    idle_inputs();
    #1;
    n_cmp++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL wrap_commit got %0b want 1", rf_wen); end
    @(negedge clock); #1;
    n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", instret); end
    $display("instret_wrap: done");
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_ecall();
    test_csr_mret();
    test_jal();
    test_reset_mid();
    test_instret_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
